// File: rtl/digital_safe_pkg.sv
// digital_safe_pkg
// Shared definitions for the digital_safe controller: FSM state constants,
// PIN digit type, 4-bit display codes, active-low 7-segment patterns
// ({g..a}) and RGB status colours.
package digital_safe_pkg;

  typedef logic [3:0] pin_digit_t;
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_LOGIN    = 3'd1;
  localparam state_t ST_UNLOCKED = 3'd2;
  localparam state_t ST_NEWPW    = 3'd3;
  localparam state_t ST_LOCKOUT  = 3'd4;

  // Display codes above 9 select non-digit glyphs.
  localparam pin_digit_t CODE_BLANK = 4'hA;
  localparam pin_digit_t CODE_DASH  = 4'hB;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [2:0] RGB_IDLE     = 3'b100;
  localparam logic [2:0] RGB_LOGIN    = 3'b001;
  localparam logic [2:0] RGB_NEWPW    = 3'b011;
  localparam logic [2:0] RGB_UNLOCKED = 3'b010;
  localparam logic [2:0] RGB_LOCKOUT  = 3'b101;

  function automatic logic [6:0] seg_decode(input pin_digit_t code);
    logic [6:0] s;
    case (code)
      4'd0:       s = SEG_0;
      4'd1:       s = SEG_1;
      4'd2:       s = SEG_2;
      4'd3:       s = SEG_3;
      4'd4:       s = SEG_4;
      4'd5:       s = SEG_5;
      4'd6:       s = SEG_6;
      4'd7:       s = SEG_7;
      4'd8:       s = SEG_8;
      4'd9:       s = SEG_9;
      CODE_BLANK: s = SEG_BLANK;
      default:    s = SEG_DASH;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] rgb_of(input state_t st);
    logic [2:0] c;
    case (st)
      ST_LOGIN:    c = RGB_LOGIN;
      ST_NEWPW:    c = RGB_NEWPW;
      ST_UNLOCKED: c = RGB_UNLOCKED;
      ST_LOCKOUT:  c = RGB_LOCKOUT;
      default:     c = RGB_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/digital_safe_seg7_scan.sv
// seg7_scan
// Display scan for the 4-digit 7-segment display. A down-counter divider
// advances the scanned digit (and toggles clko) every CLK_DIV cycles; the
// anode/segment registers are loaded from the post-advance digit index so
// they always match the code currently presented on `codes`.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   codes[15:0] four display codes, [15:12] = leftmost digit (an[3])
//   an[3:0]     active-low anodes, scan 1110 -> 1101 -> 1011 -> 0111
//   seg[6:0]    active-low segments {g..a}
//   clko        scan clock, toggles on each digit advance
module seg7_scan
  import digital_safe_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] codes,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        clko
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] div_cnt;
  logic [1:0]    idx;
  logic [1:0]    idx_nx;
  logic          tick;

  assign tick   = (div_cnt == '0);
  assign idx_nx = tick ? idx + 2'd1 : idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= CW'(CLK_DIV - 1);
      idx     <= 2'd0;
      clko    <= 1'b0;
      an      <= 4'b1110;
      seg     <= SEG_DASH;
    end else begin
      div_cnt <= tick ? CW'(CLK_DIV - 1) : div_cnt - CW'(1);
      idx     <= idx_nx;
      if (tick) clko <= ~clko;
      an      <= ~(4'b0001 << idx_nx);
      seg     <= seg_decode(codes[{idx_nx, 2'b00} +: 4]);
    end
  end

endmodule

// File: rtl/digital_safe.sv
// digital_safe
// Four-digit PIN safe controller. Decodes keypad digit events and button
// rising edges, verifies or changes the stored PIN and drives lock/status
// indicators and a multiplexed 4-digit display (via seg7_scan).
// Optional feature macro: LOCKOUT_EN -- when defined, failed logins are
// counted and MAX_ATTEMPTS consecutive failures lock the safe for
// LOCKOUT_CYCLES cycles. When undefined, failures are not counted and the
// error digit stays at 0.
// Ports:
//   clk, rst_n                           clock, synchronous active-low reset
//   startLoginBtn, logoutBtn, rstpwBtn,
//   cnf, backSpace                       buttons, level, act on rising edge
//   keypad[9:0]                          one-hot digit keys
//   an[3:0], seg[6:0], clko              display scan outputs
//   a, b, c, d                           buffered digit count >=1..4
//   p / lck                              unlocked / not unlocked
//   rgb[2:0]                             status colour {R,G,B}
//   error[6:0]                           failed-attempt count, 7-seg active-low
//
// state       | meaning
// ST_IDLE     | locked, waiting for startLoginBtn
// ST_LOGIN    | collecting a PIN attempt
// ST_UNLOCKED | safe open
// ST_NEWPW    | collecting a replacement PIN
// ST_LOCKOUT  | too many failures, all inputs ignored until timer expires
module digital_safe
  import digital_safe_pkg::*;
#(
  parameter int          CLK_DIV        = 50000,
  parameter int          MAX_ATTEMPTS   = 3,
  parameter int          LOCKOUT_CYCLES = 1000,
  parameter logic [15:0] DEFAULT_PIN    = 16'h1032
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       startLoginBtn,
  input  logic       logoutBtn,
  input  logic       rstpwBtn,
  input  logic       cnf,
  input  logic       backSpace,
  input  logic [9:0] keypad,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       p,
  output logic       lck,
  output logic [2:0] rgb,
  output logic [6:0] error,
  output logic       clko
);

  localparam int AW = $clog2(MAX_ATTEMPTS + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

  state_t      state, state_nx;
  logic [15:0] pin, pin_nx;
  pin_digit_t  ent    [4];
  pin_digit_t  ent_nx [4];
  logic [2:0]  cnt, cnt_nx;
  logic [AW-1:0] attempts, attempts_nx;
  logic [LW-1:0] lock_tmr, lock_tmr_nx;

  logic       start_q, logout_q, rstpw_q, cnf_q, bs_q;
  logic [9:0] keypad_q;
  logic       start_rise, logout_rise, rstpw_rise, cnf_rise, bs_rise;
  logic       key_onehot, key_evt;
  pin_digit_t key_val;
  logic [1:0] last_pos;
  logic [15:0] codes_nx;

  assign start_rise  = startLoginBtn & ~start_q;
  assign logout_rise = logoutBtn     & ~logout_q;
  assign rstpw_rise  = rstpwBtn      & ~rstpw_q;
  assign cnf_rise    = cnf           & ~cnf_q;
  assign bs_rise     = backSpace     & ~bs_q;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  assign key_onehot = (keypad != '0) && ((keypad & (keypad - 10'd1)) == '0);
  assign key_evt    = key_onehot && (keypad != keypad_q);
  assign last_pos   = cnt[1:0] - 2'd1;

  always_comb begin
    case (keypad)
      10'b0000000010: key_val = 4'd1;
      10'b0000000100: key_val = 4'd2;
      10'b0000001000: key_val = 4'd3;
      10'b0000010000: key_val = 4'd4;
      10'b0000100000: key_val = 4'd5;
      10'b0001000000: key_val = 4'd6;
      10'b0010000000: key_val = 4'd7;
      10'b0100000000: key_val = 4'd8;
      10'b1000000000: key_val = 4'd9;
      default:        key_val = 4'd0;
    endcase
  end

  always_comb begin
    state_nx    = state;
    pin_nx      = pin;
    ent_nx      = ent;
    cnt_nx      = cnt;
    attempts_nx = attempts;
    lock_tmr_nx = lock_tmr;

    case (state)
      ST_LOCKOUT: begin
        if (lock_tmr == '0) begin
          state_nx    = ST_IDLE;
          attempts_nx = '0;
        end else begin
          lock_tmr_nx = lock_tmr - LW'(1);
        end
      end

      ST_IDLE: begin
        if (start_rise) begin
          state_nx = ST_LOGIN;
          cnt_nx   = 3'd0;
          ent_nx   = '{default: '0};
        end
      end

      ST_UNLOCKED: begin
        if (logout_rise) begin
          state_nx = ST_IDLE;
          cnt_nx   = 3'd0;
          ent_nx   = '{default: '0};
        end else if (rstpw_rise) begin
          state_nx = ST_NEWPW;
          cnt_nx   = 3'd0;
          ent_nx   = '{default: '0};
        end
      end

      ST_LOGIN, ST_NEWPW: begin
        if (logout_rise) begin
          state_nx = ST_IDLE;
          cnt_nx   = 3'd0;
          ent_nx   = '{default: '0};
        end else if (cnf_rise) begin
          // A short buffer still consumes the cycle's action slot.
          if (cnt == 3'd4) begin
            cnt_nx = 3'd0;
            ent_nx = '{default: '0};
            if (state == ST_NEWPW) begin
              pin_nx   = {ent[0], ent[1], ent[2], ent[3]};
              state_nx = ST_UNLOCKED;
            end else if ({ent[0], ent[1], ent[2], ent[3]} == pin) begin
              state_nx    = ST_UNLOCKED;
              attempts_nx = '0;
            end else begin
`ifdef LOCKOUT_EN
              attempts_nx = attempts + AW'(1);
              if (attempts_nx >= AW'(MAX_ATTEMPTS)) begin
                state_nx    = ST_LOCKOUT;
                lock_tmr_nx = LW'(LOCKOUT_CYCLES - 1);
              end else begin
                state_nx = ST_IDLE;
              end
`else
              state_nx = ST_IDLE;
`endif
            end
          end
        end else if (bs_rise) begin
          if (cnt != 3'd0) begin
            cnt_nx           = cnt - 3'd1;
            ent_nx[last_pos] = 4'd0;
          end
        end else if (key_evt && (cnt < 3'd4)) begin
          ent_nx[cnt[1:0]] = key_val;
          cnt_nx           = cnt + 3'd1;
        end
      end

      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = 3'd0;
        ent_nx   = '{default: '0};
      end
    endcase
  end

  // Codes for the post-edge state so the scanner's registered segments line
  // up with the other registered outputs.
  always_comb begin
    if ((state_nx == ST_LOGIN) || (state_nx == ST_NEWPW)) begin
      codes_nx = {(cnt_nx >= 3'd1) ? ent_nx[0] : CODE_BLANK,
                  (cnt_nx >= 3'd2) ? ent_nx[1] : CODE_BLANK,
                  (cnt_nx >= 3'd3) ? ent_nx[2] : CODE_BLANK,
                  (cnt_nx >= 3'd4) ? ent_nx[3] : CODE_BLANK};
    end else begin
      codes_nx = {4{CODE_DASH}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pin      <= DEFAULT_PIN;
      ent      <= '{default: '0};
      cnt      <= 3'd0;
      attempts <= '0;
      lock_tmr <= '0;
      start_q  <= 1'b0;
      logout_q <= 1'b0;
      rstpw_q  <= 1'b0;
      cnf_q    <= 1'b0;
      bs_q     <= 1'b0;
      keypad_q <= '0;
      p        <= 1'b0;
      lck      <= 1'b1;
      a        <= 1'b0;
      b        <= 1'b0;
      c        <= 1'b0;
      d        <= 1'b0;
      rgb      <= RGB_IDLE;
      error    <= SEG_0;
    end else begin
      state    <= state_nx;
      pin      <= pin_nx;
      ent      <= ent_nx;
      cnt      <= cnt_nx;
      attempts <= attempts_nx;
      lock_tmr <= lock_tmr_nx;
      start_q  <= startLoginBtn;
      logout_q <= logoutBtn;
      rstpw_q  <= rstpwBtn;
      cnf_q    <= cnf;
      bs_q     <= backSpace;
      keypad_q <= keypad;
      p        <= (state_nx == ST_UNLOCKED);
      lck      <= (state_nx != ST_UNLOCKED);
      a        <= (cnt_nx >= 3'd1);
      b        <= (cnt_nx >= 3'd2);
      c        <= (cnt_nx >= 3'd3);
      d        <= (cnt_nx >= 3'd4);
      rgb      <= rgb_of(state_nx);
`ifdef LOCKOUT_EN
      error    <= seg_decode(pin_digit_t'(attempts_nx));
`else
      error    <= SEG_0;
`endif
    end
  end

  seg7_scan #(
    .CLK_DIV (CLK_DIV)
  ) u_scan (
    .clk   (clk),
    .rst_n (rst_n),
    .codes (codes_nx),
    .an    (an),
    .seg   (seg),
    .clko  (clko)
  );

endmodule

// File: tb/tb_digital_safe.sv
// tb_digital_safe
// Directed stimulus for digital_safe with a spec-level model (queue entry
// buffer, digit array PIN, cycle-stamped lockout) compared every cycle,
// plus literal spot checks at key points of the test flow.
module tb_digital_safe;

  localparam int          CLK_DIV        = 4;
  localparam int          MAX_ATTEMPTS   = 3;
  localparam int          LOCKOUT_CYCLES = 20;
  localparam logic [15:0] DEFAULT_PIN    = 16'h1032;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       startLoginBtn = 1'b0, logoutBtn = 1'b0, rstpwBtn = 1'b0;
  logic       cnf = 1'b0, backSpace = 1'b0;
  logic [9:0] keypad = '0;
  logic [3:0] an;
  logic [6:0] seg, error;
  logic       a, b, c, d, p, lck, clko;
  logic [2:0] rgb;

  digital_safe #(
    .CLK_DIV        (CLK_DIV),
    .MAX_ATTEMPTS   (MAX_ATTEMPTS),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
    .DEFAULT_PIN    (DEFAULT_PIN)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .startLoginBtn (startLoginBtn),
    .logoutBtn     (logoutBtn),
    .rstpwBtn      (rstpwBtn),
    .cnf           (cnf),
    .backSpace     (backSpace),
    .keypad        (keypad),
    .an            (an),
    .seg           (seg),
    .a             (a),
    .b             (b),
    .c             (c),
    .d             (d),
    .p             (p),
    .lck           (lck),
    .rgb           (rgb),
    .error         (error),
    .clko          (clko)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef enum int {M_IDLE, M_LOGIN, M_UNLOCKED, M_NEWPW, M_LOCKOUT} mst_t;

  mst_t       ms = M_IDLE;
  int         mq[$];
  int         mpin[4];
  int         matt = 0;
  int         n = 0;
  int         lock_start = 0;
  logic [4:0] pbtn = '0;
  logic [9:0] pkey = '0;
  logic [6:0] segtab[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic model_step();
    logic [4:0] lvl, rise;
    bit key_ev, match;
    int kd;
    if (!rst_n) begin
      ms = M_IDLE;
      mq.delete();
      for (int i = 0; i < 4; i++) mpin[i] = int'((DEFAULT_PIN >> (12 - 4*i)) & 16'hF);
      matt = 0;
      n = 0;
      pbtn = '0;
      pkey = '0;
      return;
    end
    n++;
    lvl    = {logoutBtn, rstpwBtn, startLoginBtn, cnf, backSpace};
    rise   = lvl & ~pbtn;
    key_ev = ($countones(keypad) == 1) && (keypad != pkey);
    kd = 0;
    for (int i = 0; i < 10; i++) if (keypad[i]) kd = i;
    case (ms)
      M_LOCKOUT: if (n - lock_start == LOCKOUT_CYCLES) begin ms = M_IDLE; matt = 0; end
      M_IDLE:    if (rise[2]) begin ms = M_LOGIN; mq.delete(); end
      default: begin
        if (rise[4]) begin
          ms = M_IDLE; mq.delete();
        end else if (ms == M_UNLOCKED) begin
          if (rise[3]) begin ms = M_NEWPW; mq.delete(); end
        end else if (rise[1]) begin
          if (mq.size() == 4) begin
            if (ms == M_NEWPW) begin
              for (int i = 0; i < 4; i++) mpin[i] = mq[i];
              ms = M_UNLOCKED;
            end else begin
              match = 1;
              for (int i = 0; i < 4; i++) if (mq[i] != mpin[i]) match = 0;
              if (match) begin
                ms = M_UNLOCKED; matt = 0;
              end else begin
`ifdef LOCKOUT_EN
                matt++;
                if (matt >= MAX_ATTEMPTS) begin ms = M_LOCKOUT; lock_start = n; end
                else ms = M_IDLE;
`else
                ms = M_IDLE;
`endif
              end
            end
            mq.delete();
          end
        end else if (rise[0]) begin
          if (mq.size() > 0) void'(mq.pop_back());
        end else if (key_ev && mq.size() < 4) begin
          mq.push_back(kd);
        end
      end
    endcase
    pbtn = lvl;
    pkey = keypad;
  endtask

  task automatic compare_all();
    int idx, pos, sz;
    logic [6:0] eseg;
    logic [2:0] ergb;
    logic [3:0] ean;
    idx = (n / CLK_DIV) % 4;
    pos = 3 - idx;
    sz  = mq.size();
    ean = ~(4'b0001 << idx);
    if (ms == M_LOGIN || ms == M_NEWPW) eseg = (pos < sz) ? segtab[mq[pos]] : 7'h7F;
    else eseg = 7'h3F;
    case (ms)
      M_LOGIN:    ergb = 3'b001;
      M_NEWPW:    ergb = 3'b011;
      M_UNLOCKED: ergb = 3'b010;
      M_LOCKOUT:  ergb = 3'b101;
      default:    ergb = 3'b100;
    endcase
    chk("an",    16'(an),    16'(ean));
    chk("seg",   16'(seg),   16'(eseg));
    chk("clko",  16'(clko),  16'((n / CLK_DIV) % 2));
    chk("rgb",   16'(rgb),   16'(ergb));
    chk("p",     16'(p),     16'(ms == M_UNLOCKED));
    chk("lck",   16'(lck),   16'(ms != M_UNLOCKED));
    chk("abcd",  16'({a, b, c, d}), 16'({sz >= 1, sz >= 2, sz >= 3, sz >= 4}));
    chk("error", 16'(error), 16'(segtab[matt]));
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  end

  // ---------------- stimulus ----------------
  task automatic press(input int which);
    @(negedge clk);
    case (which)
      0: backSpace = 1'b1;
      1: cnf = 1'b1;
      2: startLoginBtn = 1'b1;
      3: rstpwBtn = 1'b1;
      default: logoutBtn = 1'b1;
    endcase
    @(negedge clk);
    {backSpace, cnf, startLoginBtn, rstpwBtn, logoutBtn} = '0;
  endtask

  task automatic key(input int dg);
    @(negedge clk);
    keypad = 10'(1 << dg);
    @(negedge clk);
    keypad = '0;
  endtask

  task automatic keys4(input int k0, input int k1, input int k2, input int k3);
    key(k0); key(k1); key(k2); key(k3);
  endtask

  initial begin
    bit found;
    repeat (3) @(negedge clk);
    chk("rst_lck",   16'(lck),   16'd1);
    chk("rst_p",     16'(p),     16'd0);
    chk("rst_rgb",   16'(rgb),   16'b100);
    chk("rst_error", 16'(error), 16'b1000000);
    chk("rst_an",    16'(an),    16'b1110);
    chk("rst_seg",   16'(seg),   16'b0111111);
    chk("rst_clko",  16'(clko),  16'd0);
    chk("rst_abcd",  16'({a, b, c, d}), 16'd0);
    rst_n = 1'b1;

    // Default PIN login.
    press(2);
    chk("login_rgb", 16'(rgb), 16'b001);
    keys4(1, 0, 3, 2);
    chk("full_abcd", 16'({a, b, c, d}), 16'b1111);
    found = 0;
    for (int i = 0; i < 4*CLK_DIV + 2 && !found; i++) begin
      @(negedge clk);
      if (an == 4'b0111) found = 1;
    end
    chk("scan_left_found", 16'(found), 16'd1);
    chk("scan_left_seg",   16'(seg),   16'b1111001);
    press(1);
    chk("unlock_p",    16'(p),   16'd1);
    chk("unlock_lck",  16'(lck), 16'd0);
    chk("unlock_rgb",  16'(rgb), 16'b010);
    chk("unlock_abcd", 16'({a, b, c, d}), 16'b0000);

    // Change PIN to 2301 and log back in with it.
    press(3);
    chk("newpw_rgb", 16'(rgb), 16'b011);
    keys4(2, 3, 0, 1);
    press(1);
    chk("newpw_done_rgb", 16'(rgb), 16'b010);
    press(4);
    press(2);
    keys4(2, 3, 0, 1);
    press(1);
    chk("newpin_login_p", 16'(p), 16'd1);
    press(4);

    // Old PIN now fails.
    press(2);
    keys4(1, 0, 3, 2);
    press(1);
    chk("oldpin_rgb", 16'(rgb), 16'b100);
`ifdef LOCKOUT_EN
    chk("fail1_error", 16'(error), 16'b1111001);
`else
    chk("fail1_error", 16'(error), 16'b1000000);
`endif

    // Backspace handling and short confirm.
    press(2);
    key(4); key(5); key(6);
    press(0); press(0);
    key(7);
    chk("bs_abcd", 16'({a, b, c, d}), 16'b1100);
    press(1);
    chk("short_cnf_rgb", 16'(rgb), 16'b001);
    key(8); key(9);
    press(1);
    chk("fail2_rgb", 16'(rgb), 16'b100);
`ifdef LOCKOUT_EN
    chk("fail2_error", 16'(error), 16'b0100100);
`endif

    // rstpwBtn in IDLE is ignored.
    press(3);
    chk("idle_rstpw_rgb", 16'(rgb), 16'b100);

    // logout and cnf together: logout wins, no attempt counted.
    press(2);
    keys4(1, 1, 1, 1);
    @(negedge clk);
    logoutBtn = 1'b1; cnf = 1'b1;
    @(negedge clk);
    logoutBtn = 1'b0; cnf = 1'b0;
    chk("logout_cnf_rgb", 16'(rgb), 16'b100);
`ifdef LOCKOUT_EN
    chk("logout_cnf_error", 16'(error), 16'b0100100);
`endif

    // Multi-hot keypad ignored.
    press(2);
    @(negedge clk);
    keypad = 10'b0000000011;
    @(negedge clk);
    keypad = '0;
    chk("multihot_abcd", 16'({a, b, c, d}), 16'b0000);
    press(4);

    // Third failure.
    press(2);
    keys4(1, 1, 1, 1);
    press(1);
`ifdef LOCKOUT_EN
    chk("lockout_rgb",   16'(rgb),   16'b101);
    chk("lockout_error", 16'(error), 16'b0110000);
    press(2);
    chk("lockout_ignore_rgb", 16'(rgb), 16'b101);
    repeat (LOCKOUT_CYCLES) @(negedge clk);
    chk("lockout_exit_rgb",   16'(rgb),   16'b100);
    chk("lockout_exit_error", 16'(error), 16'b1000000);
`else
    chk("fail3_rgb", 16'(rgb), 16'b100);
`endif

    // Reset during NEWPW restores the default PIN.
    press(2);
    keys4(2, 3, 0, 1);
    press(1);
    chk("pre_reset_p", 16'(p), 16'd1);
    press(3);
    key(5); key(5);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreset_rgb", 16'(rgb), 16'b100);
    rst_n = 1'b1;
    press(2);
    keys4(1, 0, 3, 2);
    press(1);
    chk("default_pin_p", 16'(p), 16'd1);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/digital_safe.md
# digital_safe

Four-digit PIN safe controller for the board top level: decodes a 10-key one-hot keypad and five pushbuttons, verifies or changes a stored PIN, and drives lock/status LEDs, an RGB status LED, an attempt-count digit and a multiplexed 4-digit 7-segment display. Sits directly behind the board I/O; buttons arrive already debounced and synchronised.

## Interface
- CLK_DIV, 50000: display scan divider; one digit advance every CLK_DIV cycles.
- MAX_ATTEMPTS, 3: consecutive failed logins before lockout.
- LOCKOUT_CYCLES, 1000: lockout duration in clk cycles.
- DEFAULT_PIN, 16'h1032: reset PIN, four BCD digits, first-entered digit in [15:12].
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- startLoginBtn, logoutBtn, rstpwBtn, cnf, backSpace  in  1 each  buttons, level, active-high.
- keypad  in  10  one-hot digit keys; bit i = digit i.
- an  out  4  digit anodes, active-low.
- seg  out  7  segments {g..a}, active-low.
- a, b, c, d  out  1 each  digit-count LEDs: ≥1, ≥2, ≥3, 4 digits buffered.
- p  out  1  high while unlocked.
- lck  out  1  high whenever not unlocked.
- rgb  out  3  {R,G,B} status colour.
- error  out  7  failed-attempt count as an active-low 7-segment digit, using the seg encoding.
- clko  out  1  scan clock: toggles every CLK_DIV cycles.

## Operation
- States: IDLE, LOGIN, UNLOCKED, NEWPW, LOCKOUT.
- Buttons act on a rising edge: current level 1, previous-cycle level 0.
- Digit event: keypad is exactly one-hot and differs from the previous-cycle sample. Zero or multi-hot values are ignored.
- Entry buffer holds 4 digits. In LOGIN or NEWPW, a digit event appends a digit; a fifth digit is ignored. backSpace removes the last digit and is a no-op when the buffer is empty.
- IDLE: startLoginBtn → LOGIN with buffer cleared.
- UNLOCKED: rstpwBtn → NEWPW with buffer cleared. rstpwBtn is ignored in every other state.
- cnf with fewer than 4 digits does nothing.
- LOGIN cnf, buffer == PIN: → UNLOCKED, attempts cleared.
- LOGIN cnf, mismatch: attempts+1, buffer cleared, → IDLE. If attempts reaches MAX_ATTEMPTS → LOCKOUT instead.
- NEWPW cnf: PIN ← buffer, buffer cleared, → UNLOCKED.
- logoutBtn in LOGIN, UNLOCKED or NEWPW: → IDLE, buffer cleared.
- LOCKOUT: all inputs ignored. After LOCKOUT_CYCLES cycles → IDLE with attempts cleared.
- Same-cycle priority: logoutBtn > rstpwBtn > startLoginBtn > cnf > backSpace > digit. Only one action is taken per cycle.
- rgb per state: IDLE 100, LOGIN 001, NEWPW 011, UNLOCKED 010, LOCKOUT 101.
- Display in LOGIN/NEWPW: buffered digits left-justified, unfilled positions blank. All other states show four dashes (segment g only).

## Timing
- All outputs registered; they reflect an action on the cycle after the triggering edge is sampled.
- Reset values:
  - State and registers: IDLE, PIN=DEFAULT_PIN, attempts 0, buffer empty.
  - Outputs: lck=1, p=0, a..d=0, rgb=100, error=digit 0 pattern (7'b1000000), an=1110, seg=dash, clko=0.
- Scan: an rotates 1110→1101→1011→0111 every CLK_DIV cycles. The leftmost digit is an[3].
- Lockout counter counts from LOCKOUT entry; exit occurs on cycle LOCKOUT_CYCLES.
- Reset mid-entry or mid-lockout aborts immediately and restores DEFAULT_PIN.

## Configuration
- LOCKOUT_EN defined: attempt counting and the LOCKOUT state are present.
- LOCKOUT_EN undefined:
  - Failed logins return to IDLE without counting.
  - error is held at the digit 0 pattern.
  - LOCKOUT is unreachable.

## Structure
- Shared package holds:
  - state enum;
  - 7-segment constants for digits 0–9, blank and dash;
  - rgb colour constants;
  - PIN digit type.
- One sub-module, seg7_scan: a CLK_DIV divider generating clko, plus the anode/segment multiplexer over four 4-bit digit codes.

## Test plan
- Reset, then startLoginBtn; keys 1,0,3,2; cnf → p=1, lck=0, rgb=010, a..d=1111 before cnf and 0000 after.
- logoutBtn, then startLoginBtn; keys 1,1,1,1; cnf, three times → error counts 1,2,3, then rgb=101. Inputs are ignored for LOCKOUT_CYCLES, after which rgb=100 and error shows 0.
- From UNLOCKED: rstpwBtn; keys 2,3,0,1; cnf; logoutBtn; login with 2,3,0,1 → unlocked. A login with 1,0,3,2 then counts as a failure.
- LOGIN: keys 4,5,6; backSpace twice; key 7; cnf → ignored (2 digits, a,b=1). Add 8,9; cnf → mismatch, attempts=1.
- rstpwBtn in IDLE → no state change. logoutBtn and cnf asserted in the same cycle in LOGIN → IDLE, no attempt counted.
- Keypad 10'b0000000011 (multi-hot) in LOGIN → no digit buffered. Reset mid-NEWPW → IDLE with DEFAULT_PIN restored.
